// File: rtl/alu_cmd_ctrl_if.sv
// Command/ALU/transmit bus of the ALU command controller.
// The master side is the controller; the slave side is the receiver/ALU/transmitter environment.
interface alu_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   rx_p_data;
  logic                    rx_d_vld;
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [3:0]              alu_fun;
  logic                    alu_en;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_d_vld;
  logic                    tx_ready;
  logic                    err;

  modport master (
    input  rx_p_data, rx_d_vld, alu_out, out_valid, tx_ready,
    output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, err
  );

  modport slave (
    output rx_p_data, rx_d_vld, alu_out, out_valid, tx_ready,
    input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, err
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: decodes CC (A,B,FUN) and DD (FUN only) frames from the receiver,
// fires the ALU once, waits a bounded time for its result and sends it low byte first.
module alu_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WAIT_MAX   = 4
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_ctrl_if.master bus_io
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0]       CntLast = CntW'(WAIT_MAX - 1);
  localparam logic [DATA_WIDTH-1:0] CmdAb   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CmdFun  = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StGetFun, StAluGo, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    alu_en, tx_vld, err;
  logic [DATA_WIDTH-1:0]   tx_data;

  // State, operand, result and wait-counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    alu_en    = 1'b0;
    tx_vld    = 1'b0;
    tx_data   = '0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        // Unknown bytes are silently discarded while idle.
        if (bus_io.rx_d_vld) begin
          if (bus_io.rx_p_data == CmdAb) begin
            state_d = StGetA;
          end else if (bus_io.rx_p_data == CmdFun) begin
            state_d = StGetFun;
          end
        end
      end
      StGetA: begin
        if (bus_io.rx_d_vld) begin
          alu_a_d = bus_io.rx_p_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (bus_io.rx_d_vld) begin
          alu_b_d = bus_io.rx_p_data;
          state_d = StGetFun;
        end
      end
      StGetFun: begin
        if (bus_io.rx_d_vld) begin
          alu_fun_d = bus_io.rx_p_data[3:0];
          state_d   = StAluGo;
        end
      end
      StAluGo: begin
        // A result flagged in the enable cycle itself belongs to no request; ignore it.
        alu_en  = 1'b1;
        err     = bus_io.rx_d_vld;
        cnt_d   = '0;
        state_d = StAluWait;
      end
      StAluWait: begin
        err = bus_io.rx_d_vld;
        if (bus_io.out_valid) begin
          res_d   = bus_io.alu_out;
          state_d = StTxLo;
        end else if (cnt_q == CntLast) begin
          // Last allowed cycle passed without a result: abandon the frame.
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTxLo: begin
        err     = bus_io.rx_d_vld;
        tx_vld  = 1'b1;
        tx_data = res_q[DATA_WIDTH-1:0];
        if (bus_io.tx_ready) begin
          state_d = StTxHi;
        end
      end
      StTxHi: begin
        err     = bus_io.rx_d_vld;
        tx_vld  = 1'b1;
        tx_data = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (bus_io.tx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.alu_a     = alu_a_q;
  assign bus_io.alu_b     = alu_b_q;
  assign bus_io.alu_fun   = alu_fun_q;
  assign bus_io.alu_en    = alu_en;
  assign bus_io.tx_p_data = tx_data;
  assign bus_io.tx_d_vld  = tx_vld;
  assign bus_io.err       = err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a scoreboard of expected transmit bytes.
module tb_alu_cmd_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned WM = 4;

  logic CLK;
  logic RST;

  alu_cmd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .WAIT_MAX(WM)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus_io(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int en_cyc   = 0;
  int err_cnt  = 0;
  int err_cyc  = 0;

  logic [7:0]  sb_q[$];
  int          alu_delay = 0;
  logic [15:0] alu_val   = '0;
  logic [7:0]  exp_a     = '0;
  logic [7:0]  exp_b     = '0;
  logic [3:0]  exp_fun   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // ALU_EN and ERR pulse counters.
  initial forever begin
    @(negedge CLK);
    if (bus.alu_en === 1'b1) begin
      en_cnt++;
      en_cyc = cyc;
    end
    if (bus.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // ALU model: checks operands at the enable, answers alu_delay cycles later (0 = never).
  initial begin
    bus.out_valid = 1'b0;
    bus.alu_out   = '0;
    forever begin
      @(negedge CLK);
      if (RST && bus.alu_en === 1'b1) begin
        chk("alu_a_at_en", 32'(bus.alu_a), 32'(exp_a));
        chk("alu_b_at_en", 32'(bus.alu_b), 32'(exp_b));
        chk("alu_fun_at_en", 32'(bus.alu_fun), 32'(exp_fun));
        if (alu_delay > 0) begin
          repeat (alu_delay) @(posedge CLK);
          #1;
          bus.out_valid = 1'b1;
          bus.alu_out   = alu_val;
          @(posedge CLK);
          #1;
          bus.out_valid = 1'b0;
          bus.alu_out   = '0;
        end
      end
    end
  end

  // Transmit monitor: pops the scoreboard on each accepted byte, checks hold stability.
  initial begin
    logic       held;
    logic [7:0] held_d;
    held   = 1'b0;
    held_d = '0;
    forever begin
      @(negedge CLK);
      if (bus.tx_d_vld === 1'b1) begin
        if (held) chk("tx_hold_stable", 32'(bus.tx_p_data), 32'(held_d));
        if (bus.tx_ready === 1'b1) begin
          chk("tx_byte_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) chk("tx_byte", 32'(bus.tx_p_data), 32'(sb_q.pop_front()));
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_d = bus.tx_p_data;
        end
      end else begin
        held = 1'b0;
        chk("tx_idle_data_zero", 32'(bus.tx_p_data), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    step();
    bus.rx_d_vld  = 1'b0;
    bus.rx_p_data = '0;
  endtask

  task automatic setup(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                       input logic [15:0] res, input int delay, input bit push);
    exp_a     = a;
    exp_b     = b;
    exp_fun   = f;
    alu_val   = res;
    alu_delay = delay;
    if (push) begin
      sb_q.push_back(res[7:0]);
      sb_q.push_back(res[15:8]);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.tx_d_vld === 1'b1) && k < 60) begin
      step();
      k++;
    end
    chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_tx_vld_low"}, 32'(bus.tx_d_vld), 32'd0);
  endtask

  task automatic wait_tx(input string tag);
    int k;
    k = 0;
    while (bus.tx_d_vld !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_tx_vld_seen"}, 32'(bus.tx_d_vld), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    chk({tag, "_alu_fun"}, 32'(bus.alu_fun), 32'd0);
    chk({tag, "_alu_en"}, 32'(bus.alu_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_p_data), 32'd0);
    chk({tag, "_tx_vld"}, 32'(bus.tx_d_vld), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    RST           = 1'b0;
    bus.rx_p_data = '0;
    bus.rx_d_vld  = 1'b0;
    bus.tx_ready  = 1'b1;
    #12;
    check_zero("reset");
    step();
    RST = 1'b1;
    step();

    // Full CC frame, result after 2 cycles.
    en_cnt  = 0;
    err_cnt = 0;
    setup(8'h12, 8'h34, 4'h1, 16'h0024, 2, 1'b1);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    chk("t1_en_after_fun", 32'(bus.alu_en), 32'd1);
    wait_done("t1");
    chk("t1_en_pulses", 32'(en_cnt), 32'd1);
    chk("t1_err_pulses", 32'(err_cnt), 32'd0);

    // DD frame reuses held operands.
    en_cnt = 0;
    setup(8'h12, 8'h34, 4'h3, 16'h0068, 2, 1'b1);
    send(8'hDD); send(8'h03);
    wait_done("t2");
    chk("t2_en_pulses", 32'(en_cnt), 32'd1);
    chk("t2_alu_a_held", 32'(bus.alu_a), 32'h12);
    chk("t2_alu_b_held", 32'(bus.alu_b), 32'h34);

    // Timeout: the ALU never answers.
    en_cnt  = 0;
    err_cnt = 0;
    setup(8'h05, 8'h06, 4'h2, 16'h0000, 0, 1'b0);
    send(8'hCC); send(8'h05); send(8'h06); send(8'h02);
    repeat (WM + 4) step();
    chk("t3_err_pulses", 32'(err_cnt), 32'd1);
    chk("t3_err_delay", 32'(err_cyc - en_cyc), 32'(WM));
    chk("t3_en_pulses", 32'(en_cnt), 32'd1);
    chk("t3_tx_vld", 32'(bus.tx_d_vld), 32'd0);

    // Transmitter back-pressure for 5 cycles on result 0xBEEF.
    bus.tx_ready = 1'b0;
    setup(8'hAA, 8'h55, 4'h4, 16'hBEEF, 1, 1'b1);
    send(8'hCC); send(8'hAA); send(8'h55); send(8'h14);
    wait_tx("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_lo_data", 32'(bus.tx_p_data), 32'hEF);
      chk("t4_hold_lo_vld", 32'(bus.tx_d_vld), 32'd1);
      step();
    end
    bus.tx_ready = 1'b1;
    step();
    chk("t4_hi_data", 32'(bus.tx_p_data), 32'hBE);
    wait_done("t4");

    // Unknown byte in idle, then a byte dropped during the ALU wait.
    err_cnt = 0;
    send(8'h55);
    repeat (3) step();
    chk("t5_idle_no_err", 32'(err_cnt), 32'd0);
    setup(8'h21, 8'h43, 4'h5, 16'h0A0B, 3, 1'b1);
    send(8'hCC); send(8'h21); send(8'h43); send(8'h05);
    step();
    send(8'h77);
    wait_done("t5");
    chk("t5_drop_err", 32'(err_cnt), 32'd1);

    // Back-to-back: command byte in the cycle right after the high byte is accepted.
    en_cnt = 0;
    setup(8'h01, 8'h02, 4'h6, 16'h3344, 1, 1'b1);
    send(8'hCC); send(8'h01); send(8'h02); send(8'h06);
    wait_tx("t6");
    step();
    step();
    setup(8'h01, 8'h02, 4'h7, 16'h5566, 2, 1'b1);
    send(8'hDD); send(8'h07);
    wait_done("t6");
    chk("t6_en_pulses", 32'(en_cnt), 32'd2);

    // Reset mid-frame clears operands; the following DD frame sees zeros.
    en_cnt = 0;
    send(8'hCC); send(8'h12);
    RST = 1'b0;
    #2;
    check_zero("t7_rst");
    step();
    step();
    RST = 1'b1;
    repeat (3) step();
    chk("t7_no_en_after_rst", 32'(en_cnt), 32'd0);
    chk("t7_no_tx_after_rst", 32'(bus.tx_d_vld), 32'd0);
    setup(8'h00, 8'h00, 4'h0, 16'h1357, 2, 1'b1);
    send(8'hDD); send(8'h00);
    wait_done("t7");
    chk("t7_en_pulses", 32'(en_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
